median_sched: RTL and testbench

MEDIAN_SCHED -- requirements
Module: median_sched

---
 rtl/median_sched_pkg.sv | 16 +
 rtl/median_tag_pipe.sv | 37 +++
 rtl/median_sched.sv | 118 +++++++++++
 tb/tb_median_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_sched_pkg.sv
// Shared types and defaults for the median-unit scheduler.
package median_sched_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MED_LAT = 2;

  // Init pulse sequence for the median unit, then normal operation, then drain on reinit.
  typedef enum logic [2:0] {
    INIT_HI  = 3'd0,
    INIT_LO  = 3'd1,
    INIT_HI2 = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4
  } state_t;

endpackage

// File: rtl/median_tag_pipe.sv
// Tag delay line. It tracks which requester owns each result inside the
// fixed-latency median unit. A tag leaves after exactly MED_LAT cycles.
module median_tag_pipe #(
  parameter int MED_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_id,
  output logic out_vld,
  output logic out_id,
  output logic any_vld
);

  logic [MED_LAT-1:0] vld_p;
  logic [MED_LAT-1:0] id_p;

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      id_p  <= '0;
    end else begin
      vld_p[0] <= in_vld;
      id_p[0]  <= in_id;
      for (int i = 1; i < MED_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[MED_LAT-1];
  assign out_id  = id_p[MED_LAT-1];
  assign any_vld = |vld_p;

endmodule

// File: rtl/median_sched.sv
// Two-requester round-robin front end for a shared fixed-latency median unit.
// Runs the unit's reset pulse sequence, issues one triple per cycle, and routes
// each result back tagged with its requester id.
module median_sched
  import median_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MED_LAT = DEF_MED_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reinit,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [3*WIDTH-1:0]   r0_words,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [3*WIDTH-1:0]   r1_words,
  output logic                 m_rst_n,
  output logic [WIDTH-1:0]     m_word0,
  output logic [WIDTH-1:0]     m_word1,
  output logic [WIDTH-1:0]     m_word2,
  input  logic [WIDTH-1:0]     m_median_word,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 busy,
  output logic [31:0]          done_count
);

  state_t             state;
  logic               ptr;
  logic               gnt_id;
  logic               accept;
  logic [3*WIDTH-1:0] gnt_words;
  logic               tag_vld;
  logic               tag_id;
  logic               tag_any;

  // Arbitration: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt_id = ptr;
    if (r0_valid && !r1_valid) gnt_id = 1'b0;
    else if (r1_valid && !r0_valid) gnt_id = 1'b1;
    accept = (state == RUN) && !reinit && (r0_valid || r1_valid);
  end

  assign r0_ready  = accept && !gnt_id;
  assign r1_ready  = accept &&  gnt_id;
  assign gnt_words = gnt_id ? r1_words : r0_words;
  assign m_word0   = accept ? gnt_words[WIDTH-1:0]         : '0;
  assign m_word1   = accept ? gnt_words[2*WIDTH-1:WIDTH]   : '0;
  assign m_word2   = accept ? gnt_words[3*WIDTH-1:2*WIDTH] : '0;

  // Issue stage -> result stage: the tag travels alongside the median unit's latency.
  median_tag_pipe #(.MED_LAT(MED_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (accept),
    .in_id   (gnt_id),
    .out_vld (tag_vld),
    .out_id  (tag_id),
    .any_vld (tag_any)
  );

  assign rsp_valid = tag_vld;
  assign rsp_id    = tag_vld ? tag_id : 1'b0;
  assign rsp_data  = tag_vld ? m_median_word : '0;
  assign busy      = (state != RUN) || tag_any;

  // Controller: one-cycle high/low/high reset pulse for the unit, then RUN; reinit drains first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT_HI;
      m_rst_n <= 1'b1;
    end else begin
      case (state)
        INIT_HI: begin
          state   <= INIT_LO;
          m_rst_n <= 1'b0;
        end
        INIT_LO: begin
          state   <= INIT_HI2;
          m_rst_n <= 1'b1;
        end
        INIT_HI2: begin
          state   <= RUN;
          m_rst_n <= 1'b1;
        end
        RUN: begin
          if (reinit) state <= DRAIN;
          m_rst_n <= 1'b1;
        end
        DRAIN: begin
          if (!tag_any) state <= INIT_HI;
          m_rst_n <= 1'b1;
        end
        default: begin
          state   <= INIT_HI;
          m_rst_n <= 1'b1;
        end
      endcase
    end
  end

  // Priority pointer favours the loser of the last grant; survives reinit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= 1'b0;
    else if (accept) ptr <= ~gnt_id;
  end

  // Delivered-result counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_count <= '0;
    else if (tag_vld) done_count <= done_count + 32'd1;
  end

endmodule

// File: tb/tb_median_sched.sv
// Directed bench for median_sched with a behavioural fixed-latency median unit.
module tb_median_sched;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           reinit;
  logic           r0_valid, r1_valid;
  logic           r0_ready, r1_ready;
  logic [3*W-1:0] r0_words, r1_words;
  logic           m_rst_n;
  logic [W-1:0]   m_word0, m_word1, m_word2;
  logic [W-1:0]   m_median_word;
  logic           rsp_valid;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [31:0]    done_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  median_sched #(.WIDTH(W), .MED_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .reinit        (reinit),
    .r0_valid      (r0_valid),
    .r0_ready      (r0_ready),
    .r0_words      (r0_words),
    .r1_valid      (r1_valid),
    .r1_ready      (r1_ready),
    .r1_words      (r1_words),
    .m_rst_n       (m_rst_n),
    .m_word0       (m_word0),
    .m_word1       (m_word1),
    .m_word2       (m_word2),
    .m_median_word (m_median_word),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .done_count    (done_count)
  );

  // Behavioural median unit: median of the issued words, LAT cycles later.
  function automatic logic [W-1:0] med3(input logic [W-1:0] a, b, c);
    if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
    if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
    return c;
  endfunction

  logic [W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= med3(m_word0, m_word1, m_word2);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign m_median_word = mpipe[LAT-1];

  function automatic logic [3*W-1:0] trip(input int a, b, c);
    logic [W-1:0] wa, wb, wc;
    wa = W'(a); wb = W'(b); wc = W'(c);
    return {wc, wb, wa};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; reinit = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; reinit = 1'b0; r0_valid = 1'b1; r1_valid = 1'b0;
    r0_words = trip(1, 2, 3); r1_words = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy got %0b want 1", busy); else n_pass++;
    n_checks++; if (m_rst_n !== 1'b1) $display("FAIL rst_mrstn got %0b want 1", m_rst_n); else n_pass++;
    n_checks++; if (r0_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", r0_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rspv got %0b want 0", rsp_valid); else n_pass++;
    n_checks++; if (done_count !== 32'd0) $display("FAIL rst_count got %0d want 0", done_count); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (m_rst_n !== 1'b1) $display("FAIL init_c0 got %0b want 1", m_rst_n); else n_pass++;
    tick();
    n_checks++; if (m_rst_n !== 1'b0) $display("FAIL init_c1 got %0b want 0", m_rst_n); else n_pass++;
    n_checks++; if (r0_ready !== 1'b0) $display("FAIL init_ready got %0b want 0", r0_ready); else n_pass++;
    tick();
    n_checks++; if (m_rst_n !== 1'b1) $display("FAIL init_c2 got %0b want 1", m_rst_n); else n_pass++;
    tick();
    r0_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (m_word0 !== '0) $display("FAIL idle_word got %0d want 0", m_word0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    r0_valid = 1'b1; r0_words = trip(5, 1, 9);
    #1;
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL b2b_ready0 got %0b want 1", r0_ready); else n_pass++;
    n_checks++; if ({m_word2, m_word1, m_word0} !== trip(5, 1, 9))
      $display("FAIL b2b_words got %0d,%0d,%0d want 5,1,9", m_word0, m_word1, m_word2); else n_pass++;
    tick();
    r0_words = trip(7, 7, 2);
    #1;
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL b2b_ready1 got %0b want 1", r0_ready); else n_pass++;
    tick();
    r0_valid = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd5})
      $display("FAIL b2b_rsp0 got v%0b id%0d d%0d want v1 id0 d5", rsp_valid, rsp_id, rsp_data); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd7})
      $display("FAIL b2b_rsp1 got v%0b id%0d d%0d want v1 id0 d7", rsp_valid, rsp_id, rsp_data); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b0, 32'd0})
      $display("FAIL b2b_idle got v%0b id%0d d%0d want 0", rsp_valid, rsp_id, rsp_data); else n_pass++;
    n_checks++; if (done_count !== 32'd2) $display("FAIL b2b_count got %0d want 2", done_count); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      r0_valid = (i < 6); r1_valid = (i < 6);
      r0_words = trip(1, 50 + i, 99);
      r1_words = trip(300, 200 + i, 100);
      #1;
      if (i < 6) begin
        n_checks++; if ({r0_ready, r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL rr_grant%0d got r0=%0b r1=%0b want id %0d", i, r0_ready, r1_ready, i % 2); else n_pass++;
      end
      if (i >= 2) begin
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !==
            {1'b1, 1'((i - 2) % 2), ((i - 2) % 2 == 0) ? 32'(50 + i - 2) : 32'(200 + i - 2)})
          $display("FAIL rr_rsp%0d got v%0b id%0d d%0d want id%0d", i - 2, rsp_valid, rsp_id, rsp_data, (i - 2) % 2);
        else n_pass++;
      end
      tick();
    end
    n_checks++; if (done_count !== 32'd6) $display("FAIL rr_count got %0d want 6", done_count); else n_pass++;
  endtask

  task automatic test_reinit();
    r0_valid = 1'b1; r1_valid = 1'b0; r0_words = trip(4, 8, 6);
    #1;
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL ri_acc0 got %0b want 1", r0_ready); else n_pass++;
    tick();
    r0_valid = 1'b0; r1_valid = 1'b1; r1_words = trip(30, 10, 20);
    #1;
    n_checks++; if (r1_ready !== 1'b1) $display("FAIL ri_acc1 got %0b want 1", r1_ready); else n_pass++;
    tick();
    reinit = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL ri_block got %0b%0b want 00", r0_ready, r1_ready); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd6})
      $display("FAIL ri_rsp0 got v%0b id%0d d%0d want v1 id0 d6", rsp_valid, rsp_id, rsp_data); else n_pass++;
    tick();
    reinit = 1'b0; r1_valid = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'd20})
      $display("FAIL ri_rsp1 got v%0b id%0d d%0d want v1 id1 d20", rsp_valid, rsp_id, rsp_data); else n_pass++;
    n_checks++; if ({r0_ready, busy} !== 2'b01) $display("FAIL ri_drain got ready%0b busy%0b want 0 1", r0_ready, busy); else n_pass++;
    tick();
    reinit = 1'b1;
    #1;
    n_checks++; if ({rsp_valid, m_rst_n, r0_ready} !== 3'b010)
      $display("FAIL ri_drain2 got v%0b mrst%0b rdy%0b want 0 1 0", rsp_valid, m_rst_n, r0_ready); else n_pass++;
    tick();
    n_checks++; if (m_rst_n !== 1'b1) $display("FAIL ri_hi got %0b want 1", m_rst_n); else n_pass++;
    n_checks++; if (done_count !== 32'd8) $display("FAIL ri_count got %0d want 8", done_count); else n_pass++;
    tick();
    n_checks++; if (m_rst_n !== 1'b0) $display("FAIL ri_lo got %0b want 0", m_rst_n); else n_pass++;
    tick();
    reinit = 1'b0;
    #1;
    n_checks++; if ({m_rst_n, r0_ready} !== 2'b10) $display("FAIL ri_hi2 got mrst%0b rdy%0b want 1 0", m_rst_n, r0_ready); else n_pass++;
    tick();
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL ri_run got %0b want 1", r0_ready); else n_pass++;
    r0_valid = 1'b0;
  endtask

  task automatic test_rst_midflight();
    logic seen;
    tick();
    r1_valid = 1'b1; r1_words = trip(1, 2, 3);
    #1;
    n_checks++; if (r1_ready !== 1'b1) $display("FAIL mr_acc0 got %0b want 1", r1_ready); else n_pass++;
    tick();
    r1_valid = 1'b0; r0_valid = 1'b1; r0_words = trip(4, 5, 6);
    #1;
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL mr_acc1 got %0b want 1", r0_ready); else n_pass++;
    @(posedge clk);
    rst = 1'b1; r0_valid = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, busy, m_rst_n} !== 3'b011)
      $display("FAIL mr_async got v%0b busy%0b mrst%0b want 0 1 1", rsp_valid, busy, m_rst_n); else n_pass++;
    n_checks++; if (done_count !== 32'd0) $display("FAIL mr_count_rst got %0d want 0", done_count); else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin r0_valid = 1'b1; r1_valid = 1'b1; end
      #1;
      if (rsp_valid) seen = 1'b1;
      if (c == 3) begin
        n_checks++; if ({r0_ready, r1_ready} !== 2'b10)
          $display("FAIL mr_ptr got r0=%0b r1=%0b want r0", r0_ready, r1_ready); else n_pass++;
        r0_valid = 1'b0; r1_valid = 1'b0;
      end
      tick();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL mr_stale got rsp_valid seen=%0b want 0", seen); else n_pass++;
    n_checks++; if (done_count !== 32'd0) $display("FAIL mr_count got %0d want 0", done_count); else n_pass++;
  endtask

  task automatic test_wrap();
    force dut.done_count = 32'hFFFF_FFFF;
    #1;
    release dut.done_count;
    r0_valid = 1'b1; r0_words = trip(9, 3, 5);
    #1;
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL wr_acc got %0b want 1", r0_ready); else n_pass++;
    tick();
    r0_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'd5})
      $display("FAIL wr_rsp got v%0b d%0d want v1 d5", rsp_valid, rsp_data); else n_pass++;
    n_checks++; if (done_count !== 32'hFFFF_FFFF) $display("FAIL wr_pre got %h want ffffffff", done_count); else n_pass++;
    tick();
    n_checks++; if (done_count !== 32'd0) $display("FAIL wr_wrap got %h want 0", done_count); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; reinit = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    r0_words = '0; r1_words = '0;
    test_reset();
    test_back_to_back();
    test_round_robin();
    test_reinit();
    test_rst_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
